// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter.
// Holds the default line address and line data widths, the controller state
// encoding and the codes driven on the grant output.
package mips_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;   // line address, byte address [31:4]
  localparam int DATA_W_DEF = 128;  // one cache line

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Shares the single off-chip memory port between I-cache and D-cache line
// traffic. Round-robin on contention, one transaction in flight, all
// memory-side outputs registered.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   I_read/I_write/I_addr/I_wdata   I-cache request (level, held until I_ready)
//   I_ready/I_rdata           I-cache completion pulse and read line
//   D_read/D_write/D_addr/D_wdata   D-cache request (level, held until D_ready)
//   D_ready/D_rdata           D-cache completion pulse and read line
//   mem_read/mem_write        memory strobes, held for the whole transaction
//   mem_addr/mem_wdata        memory line address / write line
//   mem_ready/mem_rdata       memory completion pulse and read line
//   grant                     {D owns, I owns}, 00 when idle
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic              I_ready,
  output logic [DATA_W-1:0] I_rdata,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_ready,
  output logic [DATA_W-1:0] D_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  state_t              state, state_nxt;
  logic                last_d, last_d_nxt;  // 1: last grant went to D
  logic                mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt;
  logic                req_i, req_d, pick_d;

  assign req_i = I_read | I_write;
  assign req_d = D_read | D_write;
  // D wins when it is alone, or on contention when I was served last.
  assign pick_d = req_d & (~req_i | ~last_d);

  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rdata_nxt     = rdata_r;
    case (state)
      ST_IDLE: begin
        if (pick_d) begin
          state_nxt     = ST_BUSY_D;
          last_d_nxt    = 1'b1;
          mem_read_nxt  = D_read;
          mem_write_nxt = D_write;
          mem_addr_nxt  = D_addr;
          mem_wdata_nxt = D_wdata;
        end else if (req_i) begin
          state_nxt     = ST_BUSY_I;
          last_d_nxt    = 1'b0;
          mem_read_nxt  = I_read;
          mem_write_nxt = I_write;
          mem_addr_nxt  = I_addr;
          mem_wdata_nxt = I_wdata;
        end
      end
      // Requester inputs are not looked at here, so a dropped request
      // cannot disturb the memory operation already issued.
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready) begin
          rdata_nxt     = mem_rdata;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          state_nxt     = (state == ST_BUSY_I) ? ST_DONE_I : ST_DONE_D;
        end
      end
      // One cycle of ready; the requester drops its level request while it
      // sees the pulse, and IDLE only re-arbitrates on the following cycle.
      ST_DONE_I, ST_DONE_D: state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_r   <= '0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rdata_r   <= rdata_nxt;
    end
  end

  always_comb begin
    grant = GRANT_NONE;
    case (state)
      ST_BUSY_I, ST_DONE_I: grant = GRANT_I;
      ST_BUSY_D, ST_DONE_D: grant = GRANT_D;
      default:              grant = GRANT_NONE;
    endcase
  end

  assign I_ready = (state == ST_DONE_I);
  assign D_ready = (state == ST_DONE_D);
  assign I_rdata = rdata_r;
  assign D_rdata = rdata_r;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios followed by
// randomized two-requester traffic against a transaction-level model.
module tb_mips_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst_n;
  logic              I_read, I_write, I_ready;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_wdata, I_rdata;
  logic              D_read, D_write, D_ready;
  logic [ADDR_W-1:0] D_addr;
  logic [DATA_W-1:0] D_wdata, D_rdata;
  logic              mem_read, mem_write, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        grant;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] last_rdata;  // what the read-line holding register should show

  mips_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_ready(I_ready), .I_rdata(I_rdata),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_ready(D_ready), .D_rdata(D_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [31:0] t;
    t = $urandom;
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_reset();
    I_read = 0; I_write = 0; D_read = 0; D_write = 0; mem_ready = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    last_rdata = '0;
  endtask

  task automatic test_reset();
    I_read = 0; I_write = 0; D_read = 0; D_write = 0; mem_ready = 0;
    I_addr = '0; D_addr = '0; I_wdata = '0; D_wdata = '0; mem_rdata = '0;
    rst_n = 0;
    step(); step();
    checks++; if ({mem_read, mem_write, grant, I_ready, D_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {mem_read, mem_write, grant, I_ready, D_ready}); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem_regs got addr %h wdata %h want 0", mem_addr, mem_wdata); end
    checks++; if ({I_rdata, D_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata got %h / %h want 0", I_rdata, D_rdata); end
    rst_n = 1;
    last_rdata = '0;
    step();
    checks++; if ({mem_read, mem_write, grant} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got %b want 0000", {mem_read, mem_write, grant}); end
  endtask

  task automatic test_i_read();
    logic [DATA_W-1:0] pat;
    pat = {16{8'hA5}};
    I_read = 1; I_addr = 28'h0000010;
    step();
    checks++; if ({mem_read, mem_write, grant} !== 4'b1001) begin
      errors++; $display("FAIL iread_issue got %b want 1001", {mem_read, mem_write, grant}); end
    checks++; if (mem_addr !== 28'h0000010) begin
      errors++; $display("FAIL iread_addr got %h want 0000010", mem_addr); end
    repeat (4) step();
    checks++; if ({mem_read, mem_addr} !== {1'b1, 28'h0000010}) begin
      errors++; $display("FAIL iread_hold got %b %h want 1 0000010", mem_read, mem_addr); end
    mem_ready = 1; mem_rdata = pat;
    step();
    mem_ready = 0;
    checks++; if ({I_ready, D_ready, mem_read} !== 3'b100) begin
      errors++; $display("FAIL iread_ready got %b want 100", {I_ready, D_ready, mem_read}); end
    checks++; if (I_rdata !== pat) begin
      errors++; $display("FAIL iread_data got %h want %h", I_rdata, pat); end
    I_read = 0; last_rdata = pat;
    step();
    checks++; if ({I_ready, grant, mem_read} !== 4'b0) begin
      errors++; $display("FAIL iread_pulse_end got %b want 0000", {I_ready, grant, mem_read}); end
    step();
    checks++; if ({mem_read, grant} !== 3'b0) begin
      errors++; $display("FAIL iread_no_regrant got %b want 000", {mem_read, grant}); end
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] wd, r1, r2;
    apply_reset();
    wd = rand_line(); r1 = rand_line(); r2 = rand_line();
    I_read = 1; I_addr = 28'h1234567;
    D_write = 1; D_addr = 28'hABCDEF0; D_wdata = wd;
    step();
    checks++; if ({grant, mem_read, mem_write} !== 4'b1001) begin
      errors++; $display("FAIL cont_first_d got %b want 1001", {grant, mem_read, mem_write}); end
    checks++; if ({mem_addr, mem_wdata} !== {28'hABCDEF0, wd}) begin
      errors++; $display("FAIL cont_d_payload got %h %h want abcdef0 %h", mem_addr, mem_wdata, wd); end
    step();
    mem_ready = 1; mem_rdata = r1;
    step();
    mem_ready = 0;
    checks++; if ({D_ready, I_ready, grant, mem_write} !== 5'b10100) begin
      errors++; $display("FAIL cont_d_done got %b want 10100", {D_ready, I_ready, grant, mem_write}); end
    D_write = 0; last_rdata = r1;
    step();
    checks++; if ({grant, mem_read} !== 3'b000) begin
      errors++; $display("FAIL cont_idle got %b want 000", {grant, mem_read}); end
    step();
    checks++; if ({grant, mem_read, mem_write, mem_addr} !== {2'b01, 1'b1, 1'b0, 28'h1234567}) begin
      errors++; $display("FAIL cont_then_i got %b%b%b %h want 0110 1234567", grant, mem_read, mem_write, mem_addr); end
    mem_ready = 1; mem_rdata = r2;
    step();
    mem_ready = 0;
    checks++; if ({I_ready, I_rdata} !== {1'b1, r2}) begin
      errors++; $display("FAIL cont_i_done got %b %h want 1 %h", I_ready, I_rdata, r2); end
    I_read = 0; last_rdata = r2;
    step();
  endtask

  task automatic test_sustained();
    logic exp_d;
    logic [ADDR_W-1:0] ai, ad;
    logic [DATA_W-1:0] r;
    apply_reset();
    ai = rand_addr(); ad = rand_addr();
    I_read = 1; I_addr = ai; D_read = 1; D_addr = ad;
    exp_d = 1'b1;  // last grant after reset is I, so contention goes to D
    for (int n = 0; n < 4; n++) begin
      step();
      checks++; if ({grant, mem_addr} !== {exp_d ? 2'b10 : 2'b01, exp_d ? ad : ai}) begin
        errors++; $display("FAIL sustain_grant%0d got %b %h want %b %h", n, grant, mem_addr,
                           exp_d ? 2'b10 : 2'b01, exp_d ? ad : ai); end
      r = rand_line();
      mem_ready = 1; mem_rdata = r;
      step();
      mem_ready = 0;
      checks++; if ({D_ready, I_ready, I_rdata} !== {exp_d, ~exp_d, r}) begin
        errors++; $display("FAIL sustain_ready%0d got %b%b %h want %b%b %h", n, D_ready, I_ready, I_rdata, exp_d, ~exp_d, r); end
      last_rdata = r;
      if (exp_d) D_read = 0; else I_read = 0;
      step();
      if (exp_d) begin ad = rand_addr(); D_addr = ad; D_read = 1; end
      else begin ai = rand_addr(); I_addr = ai; I_read = 1; end
      exp_d = ~exp_d;
    end
    I_read = 0; D_read = 0;
    step();
  endtask

  task automatic test_drop();
    logic [DATA_W-1:0] r;
    r = rand_line();
    D_read = 1; D_addr = 28'h0F0F0F0;
    step();
    checks++; if ({grant, mem_read} !== 3'b101) begin
      errors++; $display("FAIL drop_issue got %b want 101", {grant, mem_read}); end
    D_read = 0;
    step(); step();
    checks++; if ({grant, mem_read, mem_addr} !== {2'b10, 1'b1, 28'h0F0F0F0}) begin
      errors++; $display("FAIL drop_hold got %b%b %h want 101 0f0f0f0", grant, mem_read, mem_addr); end
    step();
    mem_ready = 1; mem_rdata = r;
    step();
    mem_ready = 0;
    checks++; if ({D_ready, D_rdata, mem_read} !== {1'b1, r, 1'b0}) begin
      errors++; $display("FAIL drop_ready got %b %h %b want 1 %h 0", D_ready, D_rdata, mem_read, r); end
    last_rdata = r;
    step();
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] r;
    r = rand_line();
    I_read = 1; I_addr = 28'h5555550;
    step();
    checks++; if ({mem_read, grant} !== 3'b101) begin
      errors++; $display("FAIL rmid_issue got %b want 101", {mem_read, grant}); end
    #2 rst_n = 0;
    #1;
    checks++; if ({mem_read, mem_write, grant, I_ready, D_ready, mem_addr} !== '0) begin
      errors++; $display("FAIL rmid_async got %b %h want 0", {mem_read, mem_write, grant, I_ready, D_ready}, mem_addr); end
    I_read = 0;
    step();
    rst_n = 1; last_rdata = '0;
    I_addr = 28'h0AAAAA0; I_read = 1;
    step();
    checks++; if ({mem_read, grant, mem_addr} !== {1'b1, 2'b01, 28'h0AAAAA0}) begin
      errors++; $display("FAIL rmid_reissue got %b%b %h want 101 0aaaaa0", mem_read, grant, mem_addr); end
    mem_ready = 1; mem_rdata = r;
    step();
    mem_ready = 0;
    checks++; if ({I_ready, I_rdata} !== {1'b1, r}) begin
      errors++; $display("FAIL rmid_ready got %b %h want 1 %h", I_ready, I_rdata, r); end
    I_read = 0; last_rdata = r;
    step();
  endtask

  task automatic test_spurious();
    mem_ready = 1; mem_rdata = rand_line();
    step();
    mem_ready = 0;
    checks++; if ({I_ready, D_ready, grant, mem_read, mem_write} !== 6'b0) begin
      errors++; $display("FAIL spur_ctrl got %b want 000000", {I_ready, D_ready, grant, mem_read, mem_write}); end
    checks++; if (I_rdata !== last_rdata) begin
      errors++; $display("FAIL spur_rdata got %h want %h", I_rdata, last_rdata); end
    step();
    checks++; if ({I_ready, D_ready, grant} !== 4'b0) begin
      errors++; $display("FAIL spur_idle got %b want 0000", {I_ready, D_ready, grant}); end
  endtask

  // Randomized traffic. The model tracks one transaction at a time: which
  // side won, what it asked for, and when the memory answered.
  //   ph 0: the arbiter was idle last cycle, so this cycle shows its decision
  //   ph 1: transaction outstanding, memory may answer
  //   ph 2: memory answered last cycle, ready pulse expected now
  //   ph 3: pulse is over, arbiter idle this cycle
  task automatic test_random();
    int ph, delay, done_cnt, cyc, wait_i, wait_d;
    logic last_was_d, gd, exp_rd, exp_wr, op, just_done;
    logic [1:0] exp_g;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd, resp;
    apply_reset();
    ph = 0; delay = 0; done_cnt = 0; cyc = 0; wait_i = 0; wait_d = 0;
    last_was_d = 1'b0; gd = 1'b0; exp_g = 2'b00; exp_rd = 0; exp_wr = 0;
    exp_addr = '0; exp_wd = '0; resp = '0;
    while (done_cnt < 40 && cyc < 3000) begin
      step(); cyc++;
      just_done = 1'b0;
      case (ph)
        0: begin
          if (!(I_read | I_write) && !(D_read | D_write)) begin
            checks++; if ({mem_read, mem_write, grant, I_ready, D_ready} !== 6'b0) begin
              errors++; $display("FAIL rnd_idle cyc %0d got %b want 000000", cyc, {mem_read, mem_write, grant, I_ready, D_ready}); end
          end else begin
            if ((I_read | I_write) && (D_read | D_write)) gd = ~last_was_d;
            else gd = D_read | D_write;
            last_was_d = gd;
            exp_g    = gd ? 2'b10 : 2'b01;
            exp_rd   = gd ? D_read : I_read;
            exp_wr   = gd ? D_write : I_write;
            exp_addr = gd ? D_addr : I_addr;
            exp_wd   = gd ? D_wdata : I_wdata;
            checks++; if ({grant, mem_read, mem_write, mem_addr, mem_wdata} !== {exp_g, exp_rd, exp_wr, exp_addr, exp_wd}) begin
              errors++; $display("FAIL rnd_grant cyc %0d got %b%b%b %h %h want %b%b%b %h %h", cyc, grant, mem_read, mem_write,
                                 mem_addr, mem_wdata, exp_g, exp_rd, exp_wr, exp_addr, exp_wd); end
            delay = $urandom_range(0, 3);
            ph = 1;
          end
        end
        1: begin
          checks++; if ({grant, mem_read, mem_write, mem_addr, mem_wdata, I_ready, D_ready} !==
                        {exp_g, exp_rd, exp_wr, exp_addr, exp_wd, 2'b00}) begin
            errors++; $display("FAIL rnd_busy cyc %0d got %b%b%b %h want %b%b%b %h", cyc, grant, mem_read, mem_write,
                               mem_addr, exp_g, exp_rd, exp_wr, exp_addr); end
          if (delay == 0) begin
            resp = rand_line(); mem_ready = 1; mem_rdata = resp; ph = 2;
          end else delay--;
        end
        2: begin
          mem_ready = 0;
          checks++; if ({I_ready, D_ready, grant, mem_read, mem_write} !== {~gd, gd, exp_g, 2'b00}) begin
            errors++; $display("FAIL rnd_done cyc %0d got %b want %b", cyc, {I_ready, D_ready, grant, mem_read, mem_write},
                               {~gd, gd, exp_g, 2'b00}); end
          checks++; if (I_rdata !== resp || D_rdata !== resp) begin
            errors++; $display("FAIL rnd_rdata cyc %0d got %h / %h want %h", cyc, I_rdata, D_rdata, resp); end
          if (gd) begin D_read = 0; D_write = 0; end
          else begin I_read = 0; I_write = 0; end
          just_done = 1'b1;
          done_cnt++;
          ph = 3;
        end
        default: begin
          checks++; if ({grant, mem_read, mem_write, I_ready, D_ready} !== 6'b0) begin
            errors++; $display("FAIL rnd_after cyc %0d got %b want 000000", cyc, {grant, mem_read, mem_write, I_ready, D_ready}); end
          ph = 0;
        end
      endcase
      wait_i = (I_read | I_write) ? wait_i + 1 : 0;
      wait_d = (D_read | D_write) ? wait_d + 1 : 0;
      checks++; if (wait_i > 30 || wait_d > 30) begin
        errors++; $display("FAIL rnd_starve cyc %0d waited I %0d D %0d want <=30", cyc, wait_i, wait_d); end
      // Owner occasionally gives up mid-transaction; the arbiter must not care.
      if (ph == 1 && $urandom_range(0, 7) == 0) begin
        if (gd) begin D_read = 0; D_write = 0; end
        else begin I_read = 0; I_write = 0; end
      end
      if (!(I_read | I_write) && !(just_done && !gd) && !((ph == 1 || ph == 2) && !gd)
          && $urandom_range(0, 2) == 0) begin
        op = 1'($urandom_range(0, 1));
        I_read = op; I_write = ~op; I_addr = rand_addr(); I_wdata = rand_line();
      end
      if (!(D_read | D_write) && !(just_done && gd) && !((ph == 1 || ph == 2) && gd)
          && $urandom_range(0, 2) == 0) begin
        op = 1'($urandom_range(0, 1));
        D_read = op; D_write = ~op; D_addr = rand_addr(); D_wdata = rand_line();
      end
    end
    checks++; if (done_cnt < 40) begin
      errors++; $display("FAIL rnd_timeout completed %0d want 40", done_cnt); end
    I_read = 0; I_write = 0; D_read = 0; D_write = 0; mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_contention();
    test_sustained();
    test_drop();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
